// File: rtl/sorter_pkg.sv
// sorter_pkg: shared mode/load-code constants, FSM encoding and frame-size helper for the merge sorter control.
package sorter_pkg;
  localparam logic [1:0] MODE_QPSK   = 2'd0;
  localparam logic [1:0] MODE_QAM16  = 2'd1;
  localparam logic [1:0] MODE_QAM64  = 2'd2;
  localparam logic [1:0] MODE_QAM256 = 2'd3;
  localparam logic [1:0] LOAD_IDLE = 2'd0;
  localparam logic [1:0] LOAD_A    = 2'd1;
  localparam logic [1:0] LOAD_B    = 2'd2;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  function automatic int k_of_mode(input int m, input int max_log2);
    return (2 * (m + 1) > max_log2) ? max_log2 : 2 * (m + 1);
  endfunction
endpackage

// File: rtl/sorter_pass_counter.sv
// sorter_pass_counter: element/pass counter for one frame of 2^k elements over k passes, with a registered last flag.
module sorter_pass_counter #(
  parameter int MAX_LOG2 = 8,
  parameter int PASS_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                latch,
  input  logic                en,
  input  logic [PASS_W-1:0]   k_in,
  output logic [MAX_LOG2-1:0] elem,
  output logic [MAX_LOG2-1:0] elem_nx,
  output logic [PASS_W-1:0]   pass,
  output logic [PASS_W-1:0]   pass_nx,
  output logic [PASS_W-1:0]   k,
  output logic                last
);
  logic [MAX_LOG2-1:0] mask;
  logic wrap;
  always_comb begin
    mask    = MAX_LOG2'((33'd1 << k) - 33'd1);
    wrap    = elem == mask;
    elem_nx = wrap ? '0 : elem + MAX_LOG2'(1);
    pass_nx = wrap ? pass + PASS_W'(1) : pass;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      elem <= '0;
      pass <= '0;
      k    <= '0;
      last <= 1'b0;
    end else begin
      if (latch) k <= k_in;
      if (clr) begin
        elem <= '0;
        pass <= '0;
        last <= 1'b0;
      end else if (en) begin
        elem <= elem_nx;
        pass <= pass_nx;
        last <= (pass_nx == k - PASS_W'(1)) && (elem_nx == mask);
      end
    end
  end
endmodule

// File: rtl/merge_sort_ctrl.sv
// merge_sort_ctrl: sequences every merge pass of one frame, driving list-select, pass and element indices to the sorter.
module merge_sort_ctrl
  import sorter_pkg::*;
#(
  parameter int MAX_LOG2 = 8,
  parameter int PASS_W   = 4,
  parameter int MODE_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MODE_W-1:0]   M,
  input  logic                start,
  input  logic                hold,
  output logic                busy,
  output logic                done,
  output logic [1:0]          load,
  output logic [PASS_W-1:0]   pass,
  output logic [MAX_LOG2-1:0] elem,
  output logic                last_elem,
  output logic [PASS_W-1:0]   frame_log2
);
  state_t state, state_nx;
  logic busy_nx, done_nx, clr, latch, en, sel_b;
  logic [1:0] load_nx;
  logic [MAX_LOG2-1:0] elem_nx;
  logic [PASS_W-1:0] pass_nx, k_in;
  sorter_pass_counter #(.MAX_LOG2(MAX_LOG2), .PASS_W(PASS_W)) u_cnt (
    .clk(clk), .rst(rst), .clr(clr), .latch(latch), .en(en), .k_in(k_in),
    .elem(elem), .elem_nx(elem_nx), .pass(pass), .pass_nx(pass_nx),
    .k(frame_log2), .last(last_elem)
  );
  assign k_in  = PASS_W'(k_of_mode(int'(M), MAX_LOG2));
  assign sel_b = |(elem_nx & (MAX_LOG2'(1) << pass_nx));
  // load is registered, so it is derived from the element the counter is about to show
  always_comb begin
    state_nx = state;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    load_nx  = LOAD_IDLE;
    clr      = 1'b0;
    latch    = 1'b0;
    en       = 1'b0;
    case (state)
      S_RUN: begin
        busy_nx = 1'b1;
        if (!hold && last_elem) begin
          state_nx = S_DONE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          clr      = 1'b1;
        end else if (!hold) begin
          en      = 1'b1;
          load_nx = sel_b ? LOAD_B : LOAD_A;
        end
      end
      default: begin
        state_nx = start ? S_RUN : S_IDLE;
        busy_nx  = start;
        latch    = start;
        clr      = start;
        load_nx  = start ? LOAD_A : LOAD_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      load  <= LOAD_IDLE;
    end else begin
      state <= state_nx;
      busy  <= busy_nx;
      done  <= done_nx;
      load  <= load_nx;
    end
  end
endmodule
